// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift controller: state encoding and
// elaboration-time width helpers.
package serial_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Counter width able to hold value-1, never narrower than one bit.
   function automatic int cnt_width(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/bit_tick_div.sv
// Per-bit hold divider: counts down from a loaded value and flags tick while
// the count sits at zero.
module bit_tick_div
   import serial_pkg::*;
#(
   parameter int BIT_DIV = 1,
   parameter int CNT_W   = clog2(BIT_DIV) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] reload,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_q;

   // The count parks at zero, so it can never wrap below it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= reload;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/serial_shift_ctrl.sv
// Accepts one word over valid/ready and shifts it out on out_bit, holding
// each bit for BIT_DIV cycles, then pulses done for one cycle.
module serial_shift_ctrl
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BIT_DIV   = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   output logic             out_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = cnt_width(WIDTH);
   localparam int DIV_W = clog2(BIT_DIV) + 1;
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(BIT_DIV - 1);

   state_t            state_q;
   state_t            state_d;
   logic [WIDTH-1:0]  shreg_q;
   logic [BIT_W-1:0]  bitcnt_q;
   logic              ready_en_q;
   logic              tick;
   logic              accept;
   logic              bit_step;
   logic              last_step;
   logic              div_load;
   logic [DIV_W-1:0]  div_reload;

   // Handshake: a word transfers on a rising edge where in_valid and in_ready
   // are both high and abort is low; in_ready depends on state only, never on
   // in_valid, and in_data is captured at that edge and ignored afterwards.
   assign accept    = (state_q == IDLE) && in_valid && in_ready && !abort;
   assign bit_step  = (state_q == SHIFT) && tick && (bitcnt_q != '0) && !abort;
   assign last_step = (state_q == SHIFT) && tick && (bitcnt_q == '0);

   // Abort forces the divider to zero so a cancelled word leaves no residue.
   assign div_load   = accept || bit_step || abort;
   assign div_reload = abort ? '0 : DIV_RELOAD;

   bit_tick_div #(
      .BIT_DIV (BIT_DIV),
      .CNT_W   (DIV_W)
   ) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (div_load),
      .reload (div_reload),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q  <= '0;
         bitcnt_q <= '0;
      end else if (abort) begin
         shreg_q  <= '0;
         bitcnt_q <= '0;
      end else if (accept) begin
         shreg_q  <= in_data;
         bitcnt_q <= LAST_BIT;
      end else if (bit_step) begin
         shreg_q  <= MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
         bitcnt_q <= bitcnt_q - BIT_W'(1);
      end else if (last_step) begin
         shreg_q  <= '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_bit   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = ready_en_q;
            if (accept) state_d = SHIFT;
         end
         SHIFT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            if (abort) begin
               state_d = IDLE;
            end else if (last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Bench for serial_shift_ctrl: two instances (MSB-first/div 1, LSB-first/div 3)
// checked against a per-word bit-stream model.
module tb_serial_shift_ctrl;

   localparam int W    = 8;
   localparam int DIV0 = 1;
   localparam int DIV1 = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid [2];
   logic         abort    [2];
   logic [W-1:0] in_data  [2];
   logic         in_ready [2];
   logic         out_bit  [2];
   logic         out_valid[2];
   logic         busy     [2];
   logic         done     [2];

   int           n_tests;
   int           n_fail;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] src_q[$];

   always #5 clk = ~clk;

   serial_shift_ctrl #(.WIDTH(W), .BIT_DIV(DIV0), .MSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .abort(abort[0]), .out_bit(out_bit[0]),
      .out_valid(out_valid[0]), .busy(busy[0]), .done(done[0]));

   serial_shift_ctrl #(.WIDTH(W), .BIT_DIV(DIV1), .MSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .abort(abort[1]), .out_bit(out_bit[1]),
      .out_valid(out_valid[1]), .busy(busy[1]), .done(done[1]));

   function automatic int div_of(input int d);
      return (d == 0) ? DIV0 : DIV1;
   endfunction

   function automatic bit msb_of(input int d);
      return (d == 0);
   endfunction

   // Drives one word and checks every cycle of its bit stream. abort_at is the
   // 1-based SHIFT cycle on which abort is raised (W*div+1 = the done cycle).
   task automatic send_word(input int d, input logic [W-1:0] data, input int abort_at,
                            input string name);
      int   div;
      bit   msb;
      int   c;
      int   t;
      logic exp_bit;
      div = div_of(d);
      msb = msb_of(d);
      t = 0;
      while (in_ready[d] !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (in_ready[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready dut%0d got in_ready=%b want 1", name, d, in_ready[d]);
         return;
      end
      in_valid[d] = 1'b1;
      in_data[d]  = data;
      @(negedge clk);
      in_valid[d] = 1'b0;
      c = 0;
      for (int i = 0; i < W; i++) begin
         exp_bit = msb ? data[W-1-i] : data[i];
         for (int j = 0; j < div; j++) begin
            in_data[d] = W'($urandom);
            c++;
            n_tests++;
            if ({out_valid[d], busy[d], done[d], in_ready[d], out_bit[d]} !==
                {1'b1, 1'b1, 1'b0, 1'b0, exp_bit}) begin
               n_fail++;
               $display("FAIL %s_shift dut%0d cycle %0d got vld/busy/done/rdy/bit=%b%b%b%b%b want 1100%b",
                        name, d, c, out_valid[d], busy[d], done[d], in_ready[d], out_bit[d], exp_bit);
            end
            if (c == abort_at) abort[d] = 1'b1;
            @(negedge clk);
            if (c == abort_at) begin
               abort[d] = 1'b0;
               n_tests++;
               if ({out_valid[d], busy[d], done[d], in_ready[d]} !== 4'b0001) begin
                  n_fail++;
                  $display("FAIL %s_after_abort dut%0d got vld/busy/done/rdy=%b%b%b%b want 0001",
                           name, d, out_valid[d], busy[d], done[d], in_ready[d]);
               end
               return;
            end
         end
      end
      n_tests++;
      if ({out_valid[d], busy[d], done[d], in_ready[d]} !== 4'b0110) begin
         n_fail++;
         $display("FAIL %s_done dut%0d got vld/busy/done/rdy=%b%b%b%b want 0110",
                  name, d, out_valid[d], busy[d], done[d], in_ready[d]);
      end
      if (abort_at == c + 1) abort[d] = 1'b1;
      @(negedge clk);
      abort[d] = 1'b0;
      n_tests++;
      if ({out_valid[d], busy[d], done[d], in_ready[d]} !== 4'b0001) begin
         n_fail++;
         $display("FAIL %s_idle dut%0d got vld/busy/done/rdy=%b%b%b%b want 0001",
                  name, d, out_valid[d], busy[d], done[d], in_ready[d]);
      end
   endtask

   // Streams every word in src_q through dut d, rebuilding each word from the
   // observed bit stream at its done pulse and comparing against exp_q.
   task automatic run_stream(input int d, input bit rand_valid, input string name);
      int           div, cyc, last_acc, pending;
      bit           msb, acc, have, ok;
      logic         bits[$];
      logic [W-1:0] cur, got, exp_w;
      div = div_of(d);
      msb = msb_of(d);
      pending = src_q.size();
      cyc = 0;
      last_acc = -1;
      acc = 1'b0;
      have = 1'b0;
      cur = '0;
      exp_q.delete();
      while (pending > 0 && cyc < 3000) begin
         if (out_valid[d] === 1'b1) bits.push_back(out_bit[d]);
         if (done[d] === 1'b1) begin
            n_tests++;
            ok = (exp_q.size() != 0) && (bits.size() == W * div);
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            got = '0;
            if (ok) begin
               for (int i = 0; i < W; i++) begin
                  for (int j = 1; j < div; j++)
                     if (bits[i*div+j] !== bits[i*div]) ok = 1'b0;
                  if (msb) got[W-1-i] = bits[i*div];
                  else     got[i]     = bits[i*div];
               end
            end
            if (!ok || got !== exp_w) begin
               n_fail++;
               $display("FAIL %s_word dut%0d got %h (%0d bit-cycles) want %h (%0d bit-cycles)",
                        name, d, got, bits.size(), exp_w, W * div);
            end
            bits.delete();
            pending--;
         end
         if (acc) have = 1'b0;
         if (!have && src_q.size() != 0) begin
            cur = src_q.pop_front();
            have = 1'b1;
         end
         in_data[d]  = cur;
         in_valid[d] = have && (!rand_valid || ($urandom_range(0, 1) == 1));
         acc = in_valid[d] && (in_ready[d] === 1'b1);
         if (acc) begin
            exp_q.push_back(cur);
            if (!rand_valid && last_acc >= 0) begin
               n_tests++;
               if (cyc - last_acc != W * div + 2) begin
                  n_fail++;
                  $display("FAIL %s_spacing dut%0d got %0d cycles want %0d",
                           name, d, cyc - last_acc, W * div + 2);
               end
            end
            last_acc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid[d] = 1'b0;
      n_tests++;
      if (pending != 0) begin
         n_fail++;
         $display("FAIL %s_timeout dut%0d got %0d words outstanding want 0", name, d, pending);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({in_ready[d], out_valid[d], out_bit[d], busy[d], done[d]} !== 5'b00000) begin
               n_fail++;
               $display("FAIL reset_hold dut%0d got rdy/vld/bit/busy/done=%b%b%b%b%b want 00000",
                        d, in_ready[d], out_valid[d], out_bit[d], busy[d], done[d]);
            end
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if ({in_ready[d], out_valid[d], out_bit[d], busy[d], done[d]} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_release dut%0d got rdy/vld/bit/busy/done=%b%b%b%b%b want 10000",
                     d, in_ready[d], out_valid[d], out_bit[d], busy[d], done[d]);
         end
      end
   endtask

   task automatic test_msb_div1();
      send_word(0, 8'hA5, -1, "msb_a5");
   endtask

   task automatic test_lsb_div3();
      send_word(1, 8'h01, -1, "lsb_01");
   endtask

   task automatic test_back_to_back();
      for (int d = 0; d < 2; d++) begin
         src_q.delete();
         src_q.push_back(8'hFF);
         src_q.push_back(8'h00);
         run_stream(d, 1'b0, "b2b");
      end
   endtask

   task automatic test_abort();
      send_word(0, 8'hF0, 4, "abort_f0");
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h77;
      abort[0]    = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({out_valid[0], busy[0], in_ready[0]} !== 3'b001) begin
         n_fail++;
         $display("FAIL abort_vs_valid dut0 got vld/busy/rdy=%b%b%b want 001",
                  out_valid[0], busy[0], in_ready[0]);
      end
      in_valid[0] = 1'b0;
      abort[0]    = 1'b0;
      src_q.delete();
      src_q.push_back(8'h3C);
      run_stream(0, 1'b0, "post_abort");
      send_word(1, W'($urandom), $urandom_range(1, W * DIV1), "abort_rand");
      send_word(0, W'($urandom), W * DIV0 + 1, "abort_in_done");
   endtask

   task automatic test_random();
      for (int d = 0; d < 2; d++) begin
         send_word(d, W'($urandom), -1, "rand_single");
         src_q.delete();
         for (int i = 0; i < 6; i++) src_q.push_back(W'($urandom));
         run_stream(d, 1'b1, "rand_stream");
      end
   endtask

   task automatic test_async_reset();
      bit bad;
      in_valid[1] = 1'b1;
      in_data[1]  = W'($urandom_range(1, 255));
      @(negedge clk);
      in_valid[1] = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if ({out_valid[1], busy[1]} !== 2'b11) begin
         n_fail++;
         $display("FAIL areset_pre dut1 got vld/busy=%b%b want 11", out_valid[1], busy[1]);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid[1], busy[1], out_bit[1], done[1], in_ready[1]} !== 5'b00000) begin
         n_fail++;
         $display("FAIL areset_immediate dut1 got vld/busy/bit/done/rdy=%b%b%b%b%b want 00000",
                  out_valid[1], busy[1], out_bit[1], done[1], in_ready[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bad = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if ({in_ready[d], out_valid[d], busy[d], done[d]} !== 4'b1000) begin
            n_fail++;
            $display("FAIL areset_release dut%0d got rdy/vld/busy/done=%b%b%b%b want 1000",
                     d, in_ready[d], out_valid[d], busy[d], done[d]);
         end
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done[1] !== 1'b0 || out_valid[1] !== 1'b0) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL areset_quiet dut1 got activity after reset want none");
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0;
         abort[d]    = 1'b0;
         in_data[d]  = '0;
      end
      test_reset();
      test_msb_div1();
      test_lsb_div3();
      test_back_to_back();
      test_abort();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_shift_ctrl.md
Name: serial_shift_ctrl

Overview:
- Controller that sequences a parallel-load shift register built from nonblocking-assigned flops.
- Accepts one WIDTH-bit word over a valid/ready handshake and serialises it, one bit per BIT_DIV clock cycles.
- Signals completion with a one-cycle done pulse.
- Sits between a word producer and a bit-serial consumer (waveform demo, LED/UART-style output) in the lesson datapath.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- BIT_DIV, 1, clock cycles each bit is held on out_bit; legal range 1..256.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to serialise.
- abort  input  1  synchronous cancel of the current word.
- out_bit  output  1  current serial bit.
- out_valid  output  1  out_bit is meaningful.
- busy  output  1  high in SHIFT or DONE.
- done  output  1  one-cycle pulse after the last bit completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values while rst_n=0: state=IDLE, shift register=0, bit counter=0, divider=0, in_ready=0, out_valid=0, out_bit=0, busy=0, done=0.
- First cycle after reset release: in_ready=1.
- All state is updated with nonblocking assignments only. Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, out_valid=0, busy=0.
  - Accept when in_valid && in_ready && !abort at a rising edge.
  - On accept: load shreg=in_data, bitcnt=WIDTH-1, divcnt=BIT_DIV-1, next state SHIFT.
- SHIFT: in_ready=0, out_valid=1, busy=1.
  - out_bit = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Each edge with divcnt!=0: divcnt decrements.
  - Each edge with divcnt==0 and bitcnt!=0: shift one position toward the output end (zero fill), bitcnt decrements, divcnt reloads to BIT_DIV-1.
  - Each edge with divcnt==0 and bitcnt==0: next state DONE.
- DONE: one cycle. done=1, out_valid=0, busy=1, in_ready=0. Next state IDLE.
- Latency: word accepted at edge k. First bit is visible from edge k until edge k+BIT_DIV. Last bit ends at edge k+WIDTH*BIT_DIV. done is high for exactly the following cycle.
- Throughput: minimum spacing between accepts is WIDTH*BIT_DIV+2 cycles (SHIFT, DONE, then IDLE).
- in_valid held high through a transfer does not cause a second accept until IDLE.
- in_data is sampled only at the accept edge. Later changes have no effect.
- abort=1 at any edge:
  - next state is IDLE and out_valid drops after that edge;
  - shreg and counters are cleared;
  - no done pulse is produced.
- abort with in_valid in IDLE: abort wins, no accept.
- abort during DONE: done still shows for that cycle (already registered); next state IDLE.
- BIT_DIV=1: divcnt is constantly 0 and one bit shifts per cycle.
- Counters are sized clog2(WIDTH) and clog2(BIT_DIV)+1 bits (minimum 1 bit). They never wrap below 0 because reload and exit are checked at 0.
- rst_n asserted mid-word: immediate return to reset values without waiting for a clock edge.

Decomposition:
- Shared package serial_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - a clog2 helper function.
- One natural sub-module: bit_tick_div. Inputs: clk, rst_n, load, BIT_DIV-derived reload. Output: tick when the count reaches 0. The FSM, shift register and bit counter stay in serial_shift_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> all outputs 0 during reset; in_ready=1 on the first cycle after release.
- MSB_FIRST=1, BIT_DIV=1, in_data=8'hA5 accepted at edge k -> out_bit sequence 1,0,1,0,0,1,0,1 on cycles k..k+7; done=1 for the single cycle after edge k+8; in_ready=1 again one cycle later.
- MSB_FIRST=0, BIT_DIV=3, in_data=8'h01 -> out_bit=1 for 3 cycles, then 0 for 21 cycles; out_valid high for exactly 24 cycles; one done pulse.
- in_valid held high with data 8'hFF then 8'h00 -> second word accepted exactly WIDTH*BIT_DIV+2 cycles after the first; both serialised intact.
- abort asserted on the 4th SHIFT cycle of 8'hF0 -> out_valid=0 from the next cycle, no done pulse, in_ready=1; a following word 8'h3C serialises correctly.
- rst_n pulsed low mid-SHIFT, between clock edges -> out_valid and busy drop immediately (asynchronously); after release, state is IDLE with no done pulse.
